// File: rtl/arb_pkg.sv
// Shared types and widths for the two-slave burst scheduler.
package arb_pkg;

  localparam int MODE_W = 2;
  localparam int PROC_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to ptr.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_id
);

  assign gnt_valid = |req;
  assign gnt_id    = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/slv_burst_scheduler.sv
// Grants one of two slaves a burst of up to BURST_LEN beats and forwards the
// accepted beats, one cycle later, as FIFO writes tagged with their source.
module slv_burst_scheduler
  import arb_pkg::*;
#(
  parameter int DW        = 32,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] slv0_mode,
  input  logic              slv0_data_valid,
  input  logic [DW-1:0]     slv0_data,
  input  logic [PROC_W-1:0] slv0_proc_val,
  output logic              slv0_ready,
  input  logic [MODE_W-1:0] slv1_mode,
  input  logic              slv1_data_valid,
  input  logic [DW-1:0]     slv1_data,
  input  logic [PROC_W-1:0] slv1_proc_val,
  output logic              slv1_ready,
  input  logic              fifo_full,
  input  logic              mstr0_cmplt,
  output logic              slvx_data_valid,
  output logic [DW-1:0]     slvx_data,
  output logic [PROC_W-1:0] slvx_proc_val,
  output logic [MODE_W-1:0] slvx_mode,
  output logic              data_source,
  output logic              burst_done
);

  localparam logic [CNT_W-1:0] LP_LEN = CNT_W'(BURST_LEN);

  state_e            r_state, w_state_nxt;
  logic              r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_nxt;
  logic              r_grant_id, w_grant_id_nxt;
  logic [MODE_W-1:0] r_grant_mode, w_grant_mode_nxt;

  logic              w_gnt_valid, w_gnt_id;
  logic [MODE_W-1:0] w_gmode_now;
  logic              w_gvalid_now;
  logic              w_can_xfer, w_accept, w_end_burst;
  logic [CNT_W-1:0]  w_cnt_inc;

  rr_pick2 u_rr_pick2 (
    .req       ({slv1_mode != '0, slv0_mode != '0}),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_id    (w_gnt_id)
  );

  assign w_gmode_now  = r_grant_id ? slv1_mode : slv0_mode;
  assign w_gvalid_now = r_grant_id ? slv1_data_valid : slv0_data_valid;
  assign w_cnt_inc    = r_beat_cnt + 1'b1;

  // A granted slave that has dropped its request is never handed a ready,
  // so a beat offered while mode reads 0 is not acknowledged.
  assign w_can_xfer = rst_n && (r_state == ST_BURST) && !fifo_full &&
                      !mstr0_cmplt && (w_gmode_now != '0);
  assign w_accept   = w_can_xfer && w_gvalid_now;
  assign slv0_ready = w_can_xfer && !r_grant_id;
  assign slv1_ready = w_can_xfer &&  r_grant_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= 1'b0;
      r_beat_cnt   <= '0;
      r_grant_id   <= 1'b0;
      r_grant_mode <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_beat_cnt   <= w_beat_cnt_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_grant_mode <= w_grant_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_beat_cnt_nxt   = r_beat_cnt;
    w_grant_id_nxt   = r_grant_id;
    w_grant_mode_nxt = r_grant_mode;
    w_end_burst      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid && !fifo_full && !mstr0_cmplt) begin
          w_state_nxt      = ST_BURST;
          w_beat_cnt_nxt   = '0;
          w_grant_id_nxt   = w_gnt_id;
          w_grant_mode_nxt = w_gnt_id ? slv1_mode : slv0_mode;
        end
      end
      ST_BURST: begin
        if (w_gmode_now == '0) begin
          w_end_burst = 1'b1;
        end else if (mstr0_cmplt) begin
          w_state_nxt = ST_HOLD;
        end else if (w_accept) begin
          w_beat_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == LP_LEN) w_end_burst = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_gmode_now == '0) begin
          w_end_burst = 1'b1;
        end else if (!mstr0_cmplt) begin
          w_state_nxt = ST_BURST;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_end_burst) begin
      w_state_nxt  = ST_IDLE;
      w_rr_ptr_nxt = ~r_grant_id;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slvx_data_valid <= 1'b0;
      slvx_data       <= '0;
      slvx_proc_val   <= '0;
      slvx_mode       <= '0;
      data_source     <= 1'b0;
      burst_done      <= 1'b0;
    end else begin
      slvx_data_valid <= w_accept;
      burst_done      <= w_end_burst;
      // Data path holds its last beat between writes.
      if (w_accept) begin
        slvx_data     <= r_grant_id ? slv1_data : slv0_data;
        slvx_proc_val <= r_grant_id ? slv1_proc_val : slv0_proc_val;
        slvx_mode     <= r_grant_mode;
        data_source   <= r_grant_id;
      end
    end
  end

endmodule

// File: tb/tb_slv_burst_scheduler.sv
// Randomized bench for slv_burst_scheduler against a burst-level model.
module tb_slv_burst_scheduler;

  localparam int DW = 32;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    slv0_mode, slv1_mode;
  logic          slv0_data_valid, slv1_data_valid;
  logic [DW-1:0] slv0_data, slv1_data;
  logic [7:0]    slv0_proc_val, slv1_proc_val;
  logic          slv0_ready, slv1_ready;
  logic          fifo_full, mstr0_cmplt;
  logic          slvx_data_valid;
  logic [DW-1:0] slvx_data;
  logic [7:0]    slvx_proc_val;
  logic [1:0]    slvx_mode;
  logic          data_source, burst_done;

  always #5 clk = ~clk;

  slv_burst_scheduler #(.DW(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .slv0_mode(slv0_mode), .slv0_data_valid(slv0_data_valid), .slv0_data(slv0_data),
    .slv0_proc_val(slv0_proc_val), .slv0_ready(slv0_ready),
    .slv1_mode(slv1_mode), .slv1_data_valid(slv1_data_valid), .slv1_data(slv1_data),
    .slv1_proc_val(slv1_proc_val), .slv1_ready(slv1_ready),
    .fifo_full(fifo_full), .mstr0_cmplt(mstr0_cmplt),
    .slvx_data_valid(slvx_data_valid), .slvx_data(slvx_data), .slvx_proc_val(slvx_proc_val),
    .slvx_mode(slvx_mode), .data_source(data_source), .burst_done(burst_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 none), whether paused, beats so far, tie pointer.
  int         m_owner = -1;
  bit         m_paused = 1'b0;
  int         m_cnt = 0;
  int         m_ptr = 0;
  logic [1:0] m_gmode = '0;
  bit         e_valid = 1'b0, e_done = 1'b0, e_src = 1'b0;
  logic [31:0] e_data = '0;
  logic [7:0] e_proc = '0;
  logic [1:0] e_mode = '0;

  int wr_cnt [2];
  int done_cnt;
  int src_q [$];

  function automatic logic [1:0] mode_of(input int s);
    return (s == 1) ? slv1_mode : slv0_mode;
  endfunction

  task automatic end_burst_model();
    e_done  = 1'b1;
    m_ptr   = 1 - m_owner;
    m_owner = -1;
  endtask

  task automatic model_step(input bit r0, input bit r1);
    int pick;
    if (!rst_n) begin
      m_owner = -1; m_paused = 0; m_cnt = 0; m_ptr = 0; m_gmode = '0;
      e_valid = 0; e_done = 0; e_src = 0; e_data = '0; e_proc = '0; e_mode = '0;
      return;
    end
    e_valid = 0;
    e_done  = 0;
    if (m_owner < 0) begin
      if (!fifo_full && !mstr0_cmplt && (slv0_mode != 0 || slv1_mode != 0)) begin
        if (slv0_mode != 0 && slv1_mode != 0) pick = m_ptr;
        else pick = (slv1_mode != 0) ? 1 : 0;
        m_owner = pick; m_cnt = 0; m_paused = 0; m_gmode = mode_of(pick);
      end
    end else if (mode_of(m_owner) == 0) begin
      end_burst_model();
    end else if (m_paused) begin
      if (!mstr0_cmplt) m_paused = 0;
    end else if (mstr0_cmplt) begin
      m_paused = 1;
    end else if ((m_owner == 0 && r0 && slv0_data_valid) || (m_owner == 1 && r1 && slv1_data_valid)) begin
      e_valid = 1;
      e_data  = (m_owner == 1) ? slv1_data : slv0_data;
      e_proc  = (m_owner == 1) ? slv1_proc_val : slv0_proc_val;
      e_mode  = m_gmode;
      e_src   = (m_owner == 1);
      m_cnt++;
      if (m_cnt == BL) end_burst_model();
    end
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cycle();
    bit r0, r1, go;
    #1;
    go = rst_n && m_owner >= 0 && !m_paused && !fifo_full && !mstr0_cmplt;
    r0 = go && m_owner == 0 && slv0_mode != 0;
    r1 = go && m_owner == 1 && slv1_mode != 0;
    check_val("ready0", 32'(slv0_ready), 32'(r0));
    check_val("ready1", 32'(slv1_ready), 32'(r1));
    model_step(r0, r1);
    @(posedge clk);
    #1;
    check_val("wr_valid", 32'(slvx_data_valid), 32'(e_valid));
    check_val("wr_data", slvx_data, e_data);
    check_val("wr_proc", 32'(slvx_proc_val), 32'(e_proc));
    check_val("wr_mode", 32'(slvx_mode), 32'(e_mode));
    check_val("wr_src", 32'(data_source), 32'(e_src));
    check_val("burst_done", 32'(burst_done), 32'(e_done));
    if (slvx_data_valid === 1'b1) begin
      wr_cnt[data_source]++;
      src_q.push_back(int'(data_source));
    end
    if (burst_done === 1'b1) done_cnt++;
    @(negedge clk);
  endtask

  task automatic clear_stats();
    wr_cnt[0] = 0; wr_cnt[1] = 0; done_cnt = 0; src_q.delete();
  endtask

  task automatic rand_data();
    slv0_data = $urandom; slv1_data = $urandom;
    slv0_proc_val = 8'($urandom_range(0, 255));
    slv1_proc_val = 8'($urandom_range(0, 255));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rand_data();
    cycle();
    rst_n = 1'b1;
    clear_stats();
  endtask

  task automatic quiesce();
    slv0_mode = 0; slv1_mode = 0; fifo_full = 0; mstr0_cmplt = 0;
    repeat (3) cycle();
  endtask

  initial begin
    int n, left;
    bit used;
    rst_n = 0; slv0_mode = 0; slv1_mode = 0; slv0_data_valid = 0; slv1_data_valid = 0;
    slv0_data = 0; slv1_data = 0; slv0_proc_val = 0; slv1_proc_val = 0;
    fifo_full = 0; mstr0_cmplt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();

    // Lone requester: 16-beat burst then re-grant for the rest.
    slv0_mode = 1; slv0_data_valid = 1;
    n = 0;
    while (wr_cnt[0] < 20 && n < 100) begin rand_data(); cycle(); n++; end
    check_val("A_wr0", 32'(wr_cnt[0]), 20);
    check_val("A_wr1", 32'(wr_cnt[1]), 0);
    check_val("A_done", 32'(done_cnt), 1);
    quiesce();
    check_val("A_done_drop", 32'(done_cnt), 2);

    // Both requesting continuously, mode values wandering mid-burst.
    do_reset();
    slv0_data_valid = 1; slv1_data_valid = 1;
    n = 0;
    while (src_q.size() < 48 && n < 300) begin
      slv0_mode = 2'($urandom_range(1, 3)); slv1_mode = 2'($urandom_range(1, 3));
      rand_data(); cycle(); n++;
    end
    check_val("B_writes", 32'(src_q.size()), 48);
    check_val("B_src0", 32'(src_q[0]), 0);
    check_val("B_src15", 32'(src_q[15]), 0);
    check_val("B_src16", 32'(src_q[16]), 1);
    check_val("B_src31", 32'(src_q[31]), 1);
    check_val("B_src32", 32'(src_q[32]), 0);
    quiesce();

    // FIFO full for 5 cycles after beat 7.
    do_reset();
    slv0_mode = 1; slv0_data_valid = 1; slv1_data_valid = 0;
    n = 0; left = 0; used = 0;
    while (done_cnt == 0 && n < 100) begin
      if (wr_cnt[0] == 7 && !used) begin left = 5; used = 1; end
      fifo_full = (left > 0);
      if (left > 0) left--;
      rand_data(); cycle(); n++;
    end
    check_val("C_wr0", 32'(wr_cnt[0]), 16);
    check_val("C_done", 32'(done_cnt), 1);
    quiesce();

    // Downstream busy for 3 cycles after beat 4.
    do_reset();
    slv0_mode = 2; slv0_data_valid = 1;
    n = 0; left = 0; used = 0;
    while (done_cnt == 0 && n < 100) begin
      if (wr_cnt[0] == 4 && !used) begin left = 3; used = 1; end
      mstr0_cmplt = (left > 0);
      if (left > 0) left--;
      rand_data(); cycle(); n++;
    end
    check_val("D_wr0", 32'(wr_cnt[0]), 16);
    check_val("D_done", 32'(done_cnt), 1);
    quiesce();

    // slv1 withdraws after 5 beats; grant moves to slv0.
    do_reset();
    slv1_mode = 3; slv0_data_valid = 1; slv1_data_valid = 1;
    n = 0;
    while (wr_cnt[1] < 5 && n < 50) begin rand_data(); cycle(); n++; end
    slv1_mode = 0; slv0_mode = 1;
    n = 0;
    while (done_cnt == 0 && n < 5) begin rand_data(); cycle(); n++; end
    check_val("E_wr1", 32'(wr_cnt[1]), 5);
    check_val("E_done", 32'(done_cnt), 1);
    n = 0;
    while (wr_cnt[0] == 0 && n < 10) begin rand_data(); cycle(); n++; end
    check_val("E_next_src", 32'(src_q[src_q.size() - 1]), 0);

    // Reset in the middle of a slv1 burst; next grant must go to slv0.
    slv1_mode = 1;
    n = 0;
    while (wr_cnt[1] < 8 && n < 100) begin rand_data(); cycle(); n++; end
    do_reset();
    check_val("F_valid", 32'(slvx_data_valid), 0);
    check_val("F_data", slvx_data, 0);
    check_val("F_mode", 32'(slvx_mode), 0);
    check_val("F_src", 32'(data_source), 0);
    n = 0;
    while (src_q.size() == 0 && n < 10) begin rand_data(); cycle(); n++; end
    check_val("F_first_src", 32'(src_q[0]), 0);
    quiesce();

    // Free-running random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) slv0_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) slv1_mode = 2'($urandom_range(0, 3));
      slv0_data_valid = ($urandom_range(0, 3) != 0);
      slv1_data_valid = ($urandom_range(0, 3) != 0);
      fifo_full   = ($urandom_range(0, 7) == 0);
      mstr0_cmplt = ($urandom_range(0, 9) == 0);
      rst_n       = ($urandom_range(0, 499) != 0);
      rand_data();
      cycle();
    end
    rst_n = 1;
    check_val("G_bursts_seen", 32'(done_cnt > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slv_burst_scheduler.md
SLV_BURST_SCHEDULER -- requirements
Module: slv_burst_scheduler

Interface
REQ-001 SHALL have parameter DW, default 32, data width of each slave beat.
REQ-002 SHALL have parameter BURST_LEN, default 16, max beats per grant (2..255).
REQ-003 SHALL have ports clk in 1, single rising-edge clock; rst_n in 1, reset, synchronous, active-low.
REQ-004 SHALL have ports slv0_mode in 2, slv0 request (nonzero = requesting, value = processing mode); slv0_data_valid in 1, beat valid; slv0_data in DW, beat data; slv0_proc_val in 8, per-beat processing value; slv0_ready out 1, beat accepted when high with valid.
REQ-005 SHALL have the same five ports for slv1 (slv1_mode, slv1_data_valid, slv1_data, slv1_proc_val, slv1_ready).
REQ-006 SHALL have ports fifo_full in 1, FIFO cannot take a write next cycle; mstr0_cmplt in 1, downstream master busy/complete, pauses transfers.
REQ-007 SHALL have ports slvx_data_valid out 1, FIFO write strobe; slvx_data out DW; slvx_proc_val out 8; slvx_mode out 2; data_source out 1 (0 = slv0, 1 = slv1); burst_done out 1, one-cycle pulse at burst end.

Function
REQ-008 SHALL implement FSM states IDLE, BURST, HOLD.
REQ-009 IDLE: if exactly one slave has mode != 0, grant it; if both, grant the slave pointed to by rr_ptr; on grant go BURST, beat_cnt = 0, latch grant_id and grant_mode.
REQ-010 IDLE with no requester, or with fifo_full or mstr0_cmplt high, SHALL stay IDLE with no grant.
REQ-011 slvN_ready SHALL be combinational = (state==BURST) && (grant_id==N) && !fifo_full && !mstr0_cmplt; the ungranted slave's ready SHALL be 0.
REQ-012 A beat SHALL be accepted on a cycle with slvN_ready && slvN_data_valid; exactly one cycle later slvx_data_valid=1 with the accepted data, proc_val, grant_mode and data_source=grant_id.
REQ-013 Cycles without an accepted beat SHALL leave slvx_data_valid=0 next cycle; slvx_data SHALL hold its last value (no zeroing).
REQ-014 beat_cnt (8 bit) SHALL increment per accepted beat; the accept that makes beat_cnt reach BURST_LEN ends the burst.
REQ-015 Burst SHALL also end when the granted slave's mode reads 0 in BURST (beat in that cycle is not accepted).
REQ-016 On burst end: go IDLE, rr_ptr = ~grant_id, burst_done = 1 for the following cycle.
REQ-017 mstr0_cmplt high in BURST SHALL move to HOLD next cycle, keeping grant_id and beat_cnt; HOLD returns to BURST when mstr0_cmplt low; granted mode going 0 in HOLD ends burst per REQ-016.
REQ-018 fifo_full in BURST SHALL only deassert ready (REQ-011); no state change, no beat lost or duplicated.
REQ-019 Changing the granted slave's mode value mid-burst SHALL not alter slvx_mode until next grant; only transition to 0 is honoured.
REQ-020 Back-to-back requests from both slaves SHALL alternate grants; a continuously requesting slave SHALL never wait more than one burst.

Reset
REQ-021 With rst_n low at a clock edge: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, slvx_data_valid=0, slvx_data=0, slvx_proc_val=0, slvx_mode=0, data_source=0, burst_done=0.
REQ-022 slv0_ready and slv1_ready SHALL be 0 during reset and in the first cycle after.
REQ-023 Reset mid-burst SHALL drop the burst immediately; the beat accepted in the reset cycle SHALL not be written.

Structure
REQ-024 State enum, mode width (2) and proc_val width (8) SHALL live in shared package arb_pkg.
REQ-025 Round-robin pick logic SHALL be sub-module rr_pick2 (inputs req[1:0], ptr; outputs gnt_valid, gnt_id).
REQ-026 All outputs except slvN_ready SHALL be registered.

Verification
REQ-027 Only slv0 mode=1, 20 valid beats, BURST_LEN=16 -> 16 writes data_source=0, burst_done, re-grant slv0, 4 more writes.
REQ-028 Both modes nonzero, continuous valid -> grants slv0,slv1,slv0 (16 beats each), data_source toggles every 16 writes.
REQ-029 fifo_full high 5 cycles at beat 7 -> ready low those cycles, no writes, beats 8..16 resume, total 16 exactly.
REQ-030 mstr0_cmplt pulse 3 cycles at beat 4 -> HOLD, ready 0, resume at beat_cnt 4, no data loss.
REQ-031 slv1 mode drops to 0 after 5 beats -> burst ends, 5 writes, burst_done pulse, grant moves to slv0.
REQ-032 rst_n low for 1 cycle mid-burst -> all outputs per REQ-021 next cycle, rr_ptr=0, next grant slv0.
